fifo_wr_arbiter: RTL

- Round-robin write arbiter that shares one FIFO write port between N_REQ requesters.
- Sits in front of the FIFO. Drives the FIFO's wr_en and data_in, and reads back its full, almostfull, wr_ack and overflow.
- Grants bursts of up to BURST_LEN beats per owner.
- Throttles on FIFO status so that, with a correct FIFO, overflow never occurs.

---
 rtl/fifo_arb_pkg.sv | 49 ++++
 rtl/fifo_wr_arbiter_rr_picker.sv | 33 +++
 rtl/fifo_wr_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types, defaults and round-robin search helper
// for the FIFO write arbiter.
package fifo_arb_pkg;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_N_REQ      = 4;
  localparam int DEF_BURST_LEN  = 4;
  localparam int MAX_REQ        = 8;

  typedef enum logic {
    IDLE,
    BURST
  } arb_state_e;

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit at or above ptr, else first set bit
  // from zero: an upward search from ptr modulo n.
  function automatic rr_pick_t rr_pick(
    input logic [MAX_REQ-1:0] req,
    input logic [2:0]         ptr,
    input int                 n
  );
    rr_pick_t   r;
    logic       hi_v, lo_v;
    logic [2:0] hi, lo;
    hi_v = 1'b0;
    lo_v = 1'b0;
    hi   = '0;
    lo   = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n && req[i]) begin
        lo_v = 1'b1;
        lo   = 3'(i);
        if (3'(i) >= ptr) begin
          hi_v = 1'b1;
          hi   = 3'(i);
        end
      end
    end
    r.valid = hi_v | lo_v;
    r.idx   = hi_v ? hi : lo;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin winner search starting at ptr.
// Ports: req (N_REQ) and ptr in; valid, idx (winner) out.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] idx
);

  localparam int IW = $clog2(N_REQ);

  logic [MAX_REQ-1:0] req_x;
  logic [2:0]         ptr_x;
  rr_pick_t           pick;
  logic               unused_pick;

  always_comb begin
    req_x            = '0;
    req_x[N_REQ-1:0] = req;
    ptr_x            = '0;
    ptr_x[IW-1:0]    = ptr;
    pick             = rr_pick(req_x, ptr_x, N_REQ);
  end

  assign valid       = pick.valid;
  assign idx         = pick.idx[IW-1:0];
  assign unused_pick = ^pick.idx;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among
// N_REQ requesters, in bursts of up to BURST_LEN beats.
// In : clk, rst (async, high), req, req_data (flattened),
//      fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow.
// Out: gnt (registered one-hot), accept (comb), fifo_wr_en,
//      fifo_data_in (registered), busy (in BURST).
// Option ARB_ACK_CHECK_EN adds err_sticky, set on overflow
// or on a missing write acknowledge, cleared only by rst.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int N_REQ      = DEF_N_REQ,
  parameter int BURST_LEN  = DEF_BURST_LEN
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            accept,
  output logic                        fifo_wr_en,
  output logic [FIFO_WIDTH-1:0]       fifo_data_in,
  input  logic                        fifo_full,
  input  logic                        fifo_almostfull,
  input  logic                        fifo_wr_ack,
  input  logic                        fifo_overflow,
`ifdef ARB_ACK_CHECK_EN
  output logic                        err_sticky,
`endif
  output logic                        busy
);

  localparam int         IW        = $clog2(N_REQ);
  localparam logic [3:0] LAST_BEAT = 4'(BURST_LEN - 1);

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         owner_q, owner_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [3:0]            beat_cnt_q, beat_cnt_d;
  logic [N_REQ-1:0]      gnt_q, gnt_d;
  logic                  fifo_wr_en_q, fifo_wr_en_d;
  logic [FIFO_WIDTH-1:0] fifo_data_in_q, fifo_data_in_d;

  logic                  pick_valid;
  logic [IW-1:0]         pick_idx;
  logic                  space;
  logic                  owner_req;
  logic                  fire;
  logic [FIFO_WIDTH-1:0] req_slice [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign req_slice[g] =
      req_data[g*FIFO_WIDTH +: FIFO_WIDTH];
  end

  rr_picker #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // The in-flight write is not yet counted by the FIFO,
  // so almostfull plus a pending write means no room.
  assign space = !fifo_full &&
                 !(fifo_almostfull && fifo_wr_en_q);

  assign owner_req = req[owner_q];
  assign fire      = (state_q == BURST) && owner_req && space;

  always_comb begin
    accept = '0;
    if (fire && !rst) accept[owner_q] = 1'b1;
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    rr_ptr_d       = rr_ptr_q;
    beat_cnt_d     = beat_cnt_q;
    gnt_d          = gnt_q;
    fifo_wr_en_d   = 1'b0;
    fifo_data_in_d = fifo_data_in_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d           = pick_idx;
          gnt_d             = '0;
          gnt_d[pick_idx]   = 1'b1;
          beat_cnt_d        = '0;
          state_d           = BURST;
        end
      end
      BURST: begin
        if (fire) begin
          fifo_wr_en_d   = 1'b1;
          fifo_data_in_d = req_slice[owner_q];
          beat_cnt_d     = beat_cnt_q + 1'b1;
        end
        if (!owner_req ||
            (fire && beat_cnt_q == LAST_BEAT)) begin
          state_d  = IDLE;
          gnt_d    = '0;
          rr_ptr_d = (owner_q == IW'(N_REQ - 1)) ?
                     '0 : owner_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= '0;
      rr_ptr_q       <= '0;
      beat_cnt_q     <= '0;
      gnt_q          <= '0;
      fifo_wr_en_q   <= 1'b0;
      fifo_data_in_q <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      rr_ptr_q       <= rr_ptr_d;
      beat_cnt_q     <= beat_cnt_d;
      gnt_q          <= gnt_d;
      fifo_wr_en_q   <= fifo_wr_en_d;
      fifo_data_in_q <= fifo_data_in_d;
    end
  end

  assign gnt          = gnt_q;
  assign fifo_wr_en   = fifo_wr_en_q;
  assign fifo_data_in = fifo_data_in_q;
  assign busy         = (state_q == BURST);

`ifdef ARB_ACK_CHECK_EN
  // The FIFO acks one cycle after the write edge, so the
  // ack is compared against wr_en delayed by one cycle.
  logic wr_en_d1_q, wr_en_d1_d;
  logic err_q, err_d;

  always_comb begin
    wr_en_d1_d = fifo_wr_en_q;
    err_d      = err_q | fifo_overflow |
                 (wr_en_d1_q & ~fifo_wr_ack);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en_d1_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_en_d1_q <= wr_en_d1_d;
      err_q      <= err_d;
    end
  end

  assign err_sticky = err_q;
`else
  logic unused_status;
  assign unused_status = fifo_wr_ack ^ fifo_overflow;
`endif

endmodule
